// File: rtl/logic_op_pkg.sv
// Shared op encodings and the bitwise result function used by both the
// combinational path and the first pipeline stage.
package logic_op_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_AND  = 2'b00;
   localparam op_t OP_OR   = 2'b01;
   localparam op_t OP_XOR  = 2'b10;
   localparam op_t OP_NAND = 2'b11;

   // Per-bit so callers of any width can apply it across a vector.
   function automatic logic op_bit(input logic a, input logic b, input op_t op);
      logic r;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NAND: r = ~(a & b);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_op_stage.sv
// One elastic register stage: on load it takes the upstream valid/data;
// data is only overwritten when the incoming slot is valid.
module logic_op_stage #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_i,
   input  logic             vld_i,
   input  logic [WIDTH-1:0] dat_i,
   output logic             vld_o,
   output logic [WIDTH-1:0] dat_o
);

   logic             vld_q, vld_d;
   logic [WIDTH-1:0] dat_q, dat_d;

   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (ld_i) begin
         vld_d = vld_i;
         if (vld_i) dat_d = dat_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= 1'b0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign vld_o = vld_q;
   assign dat_o = dat_q;

endmodule

// File: rtl/logic_op_pipe.sv
// Bitwise AND/OR/XOR/NAND unit with a combinational result and a
// STAGES-deep valid/ready pipelined result plus an accept counter.
module logic_op_pipe
   import logic_op_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] y_comb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             y_zero,
   output logic [CNT_W-1:0] op_count
);

   logic [STAGES-1:0]            vld;
   logic [STAGES-1:0][WIDTH-1:0] dat;
   logic [STAGES-1:0]            up_vld;
   logic [STAGES-1:0][WIDTH-1:0] up_dat;
   logic [STAGES:0]              rdy;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         accept;

   always_comb begin
      y_comb = '0;
      for (int i = 0; i < WIDTH; i++) y_comb[i] = op_bit(a[i], b[i], op);
   end

   // rdy[k]: stage k may load this cycle (empty, or its contents advance).
   always_comb begin
      rdy         = '0;
      rdy[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) rdy[k] = !vld[k] || rdy[k+1];
   end

   always_comb begin
      up_vld    = '0;
      up_dat    = '0;
      up_vld[0] = in_valid;
      up_dat[0] = y_comb;
      for (int k = 1; k < STAGES; k++) begin
         up_vld[k] = vld[k-1];
         up_dat[k] = dat[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic_op_stage #(.WIDTH(WIDTH)) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .ld_i  (rdy[k]),
         .vld_i (up_vld[k]),
         .dat_i (up_dat[k]),
         .vld_o (vld[k]),
         .dat_o (dat[k])
      );
   end

   assign in_ready  = rdy[0];
   assign accept    = in_valid && rdy[0];
   assign out_valid = vld[STAGES-1];
   assign y         = dat[STAGES-1];
   assign y_zero    = out_valid && (y == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (accept) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign op_count = cnt_q;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Scoreboard bench: driver pushes expected results on accept, a negedge
// monitor pops and compares on each output transfer.
module tb_logic_op_pipe;
  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic             in_ready, out_valid, y_zero;
  logic [WIDTH-1:0] a = '0, b = '0, y_comb, y;
  logic [1:0]       op = 2'b00;
  logic [CNT_W-1:0] op_count;

  int checks = 0, failures = 0;
  logic [WIDTH-1:0] exp_q[$];
  int exp_cnt = 0;
  int n_out = 0;
  bit rnd_rdy = 1'b0;
  bit prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_y = '0;

  logic_op_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .y_comb(y_comb), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .y_zero(y_zero), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z, input logic [1:0] o);
    case (o)
      2'd0:    return x & z;
      2'd1:    return x | z;
      2'd2:    return x ^ z;
      default: return ~(x & z);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: in_ready model, zero flag, stall hold, ordered result compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", in_ready, (exp_q.size() < STAGES) || out_ready);
      chk("y_zero", y_zero, out_valid && exp_q.size() > 0 && exp_q[0] == '0);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", y, prev_y);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_out: got y=%0h expected no output", y);
        end else begin
          chk("y", y, exp_q.pop_front());
          n_out++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = y;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // All driver tasks start and end at posedge+1.
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic [1:0] to);
    bit acc = 1'b0;
    a = ta; b = tb_; op = to; in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      chk("y_comb", y_comb, ref_op(ta, tb_, to));
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(ref_op(ta, tb_, to));
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      end
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    if (!rnd_rdy) out_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    // in_valid held high to show the reset edge blocks an accept.
    a = 8'h12; b = 8'h34; op = 2'd1; in_valid = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    exp_q.delete();
    exp_cnt = 0;
    #1 rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_y_zero", y_zero, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_cnt(input string name);
    @(negedge clk);
    chk(name, op_count, exp_cnt);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] tab [4];
    int lat, n0, n_acc;
    bit acc;
    tab[0] = 8'h30; tab[1] = 8'hFC; tab[2] = 8'hCC; tab[3] = 8'hCF;

    @(posedge clk); #1;
    do_reset();

    // Op coverage with latency and spec result table.
    out_ready = 1'b1;
    for (int o = 0; o < 4; o++) begin
      send(8'hF0, 8'h3C, 2'(o));
      lat = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (out_valid) break;
        @(posedge clk);
        lat++;
      end
      chk("latency", lat, STAGES - 1);
      chk("op_y", y, tab[o]);
      @(posedge clk); #1;
      drain();
    end

    // Zero flag.
    send(8'hAA, 8'h55, 2'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("zero_y", y, 0);
    chk("zero_flag", y_zero, 1);
    @(posedge clk); #1;
    drain();

    // Streaming: 10 back-to-back, no gaps.
    do_reset();
    n0 = n_out;
    for (int i = 0; i < 10; i++) send(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
    repeat (STAGES - 1) @(posedge clk);
    @(negedge clk); #1;
    chk("stream_count", n_out - n0, 10);
    @(posedge clk); #1;
    chk("stream_opcount", op_count, 10);
    drain();

    // Back-pressure: exactly STAGES accepts while out_ready is low.
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < STAGES + 4; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 2'($urandom_range(0, 3)); in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(ref_op(a, b, op));
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        n_acc++;
      end
      #1;
    end
    in_valid = 1'b0;
    chk("bp_accepts", n_acc, STAGES);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    @(posedge clk); #1;
    drain();
    check_cnt("bp_opcount");

    // Reset mid-flight: two results in the pipe are discarded.
    out_ready = 1'b0;
    send(8'h0F, 8'hFF, 2'd1);
    send(8'h33, 8'h0F, 2'd2);
    do_reset();
    out_ready = 1'b1;
    idle(8);
    chk("post_rst_no_out", n_out - n_out, 0);

    // Counter wrap at CNT_W = 4.
    for (int i = 0; i < 17; i++) send(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
    drain();
    @(negedge clk);
    chk("wrap_opcount", op_count, 1);
    @(posedge clk); #1;

    // Randomized traffic with random back-pressure.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
    end
    rnd_rdy = 1'b0;
    @(posedge clk); #1;
    drain();
    check_cnt("rand_opcount");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
